// File: rtl/mem_wbuf.sv
// Posted-write buffer: writes are acked on entry to a DEPTH-deep FIFO and drained
// in order; reads wait for an empty FIFO and then pass straight through to memory.
module mem_wbuf #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     up_valid,
   output logic                     up_ready,
   input  logic [31:0]              up_addr,
   output logic [31:0]              up_rdata,
   input  logic [31:0]              up_wdata,
   input  logic [3:0]               up_wstrb,
   output logic                     mem_valid,
   input  logic                     mem_ready,
   output logic [31:0]              mem_addr,
   input  logic [31:0]              mem_rdata,
   output logic [31:0]              mem_wdata,
   output logic [3:0]               mem_wstrb,
   output logic [$clog2(DEPTH):0]   wbuf_level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

   typedef enum logic {IDLE, READ} state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } entry_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW:0]     level_q, level_d;
   logic            ack_q, ack_d;
   entry_t          fifo_q [DEPTH];
   entry_t          head;

   logic empty, full, in_read, push, pop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == FULL_LVL);
   assign in_read = (state_q == READ);
   // ack_q blocks a second push of the same request while its ack is on the wire
   assign push    = (state_q == IDLE) && up_valid && (up_wstrb != 4'h0) && !full && !ack_q;
   assign pop     = !empty && mem_ready;
   assign head    = fifo_q[rd_ptr_q];

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ack_d    = push;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
      case (state_q)
         IDLE: if (up_valid && (up_wstrb == 4'h0) && empty) state_d = READ;
         READ: if (mem_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ack_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ack_q    <= ack_d;
      end
   end

   // Entry storage is not reset; occupancy is tracked solely by level_q.
   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= '{addr: up_addr, wdata: up_wdata, wstrb: up_wstrb};
   end

   always_comb begin
      mem_valid = !empty || in_read;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = '0;
      if (in_read) begin
         mem_addr  = up_addr;
         mem_wdata = up_wdata;
      end else if (!empty) begin
         mem_addr  = head.addr;
         mem_wdata = head.wdata;
         mem_wstrb = head.wstrb;
      end
      up_ready = ack_q || (in_read && mem_ready);
      up_rdata = (in_read && mem_ready) ? mem_rdata : '0;
   end

   assign wbuf_level = level_q;

endmodule

// File: tb/tb_mem_wbuf.sv
// Directed bench for mem_wbuf: a per-cycle vector table for the basic write/read
// handshakes, then hand sequences for full, read-behind-write, wrap, collision and reset.
module tb_mem_wbuf;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        up_valid = 1'b0, up_ready;
   logic [31:0] up_addr = '0, up_rdata, up_wdata = '0;
   logic [3:0]  up_wstrb = '0;
   logic        mem_valid, mem_ready = 1'b0;
   logic [31:0] mem_addr, mem_rdata = '0, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [2:0]  wbuf_level;

   mem_wbuf #(.DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .up_valid(up_valid), .up_ready(up_ready), .up_addr(up_addr), .up_rdata(up_rdata),
      .up_wdata(up_wdata), .up_wstrb(up_wstrb),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .wbuf_level(wbuf_level)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } txn_t;

   typedef struct {
      logic        v;
      logic [31:0] a, d;
      logic [3:0]  s;
      logic        mr;
      logic [31:0] mrd;
      logic        e_rdy;
      logic [31:0] e_rdata;
      logic        e_mv;
      logic [31:0] e_maddr, e_mwdata;
      logic [3:0]  e_mstrb;
      logic [2:0]  e_lvl;
   } vec_t;

   int   checks = 0, errors = 0;
   int   max_level = 0;
   int   mon_base = 0;
   txn_t mon_q[$];
   txn_t exp_q[$];
   vec_t vecs [11];

   always @(posedge clk)
      if (rst && mem_valid && mem_ready) mon_q.push_back({mem_addr, mem_wdata, mem_wstrb});

   function automatic vec_t mk(input logic v, input logic [31:0] a, d, input logic [3:0] s,
                               input logic mr, input logic [31:0] mrd,
                               input logic er, input logic [31:0] erd, input logic emv,
                               input logic [31:0] ema, emd, input logic [3:0] ems,
                               input logic [2:0] el);
      vec_t r;
      r.v = v; r.a = a; r.d = d; r.s = s; r.mr = mr; r.mrd = mrd;
      r.e_rdy = er; r.e_rdata = erd; r.e_mv = emv; r.e_maddr = ema;
      r.e_mwdata = emd; r.e_mstrb = ems; r.e_lvl = el;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: timed out", nm);
   endtask

   task automatic cmp_q(input string nm);
      int n;
      n = mon_q.size() - mon_base;
      chk({nm, "_count"}, 32'(n), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < n; i++) begin
         chk($sformatf("%s_addr%0d", nm, i), mon_q[mon_base+i].addr, exp_q[i].addr);
         chk($sformatf("%s_wdata%0d", nm, i), mon_q[mon_base+i].wdata, exp_q[i].wdata);
         chk($sformatf("%s_wstrb%0d", nm, i), 32'(mon_q[mon_base+i].wstrb), 32'(exp_q[i].wstrb));
      end
      mon_base = mon_q.size();
      exp_q.delete();
   endtask

   task automatic track_level();
      if (int'(wbuf_level) > max_level) max_level = int'(wbuf_level);
   endtask

   // Issues one write, waits for its ack, then spends one idle cycle so the next
   // request starts clean; lat is the number of edges from request to ack.
   task automatic wr(input logic [31:0] a, d, input logic [3:0] s, output int lat);
      up_valid = 1'b1; up_addr = a; up_wdata = d; up_wstrb = s;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         track_level();
         if (up_ready) begin
            lat = k;
            break;
         end
      end
      up_valid = 1'b0; up_addr = '0; up_wdata = '0; up_wstrb = '0;
      if (lat < 0) timeout("wr_ack");
      else exp_q.push_back({a, d, s});
      @(posedge clk); #1;
      track_level();
      chk("ack_pulse", 32'(up_ready), 32'd0);
   endtask

   task automatic drain(input string nm);
      bit ok;
      ok = 1'b0;
      mem_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (wbuf_level == 3'd0) begin
            ok = 1'b1;
            break;
         end
      end
      mem_ready = 1'b0;
      if (!ok) timeout(nm);
   endtask

   initial begin
      int  lat;
      bit  got;

      vecs[0]  = mk(1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0,            0, 0,            0, 0,      0,            4'h0, 3'd0);
      vecs[1]  = mk(1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 0,            1, 0,            1, 32'h100, 32'hDEADBEEF, 4'hF, 3'd1);
      vecs[2]  = mk(0, 0,       0,            4'h0, 0, 0,            0, 0,            1, 32'h100, 32'hDEADBEEF, 4'hF, 3'd1);
      vecs[3]  = mk(0, 0,       0,            4'h0, 1, 0,            0, 0,            1, 32'h100, 32'hDEADBEEF, 4'hF, 3'd1);
      vecs[4]  = mk(0, 0,       0,            4'h0, 0, 0,            0, 0,            0, 0,      0,            4'h0, 3'd0);
      vecs[5]  = mk(1, 32'h200, 0,            4'h0, 0, 0,            0, 0,            0, 0,      0,            4'h0, 3'd0);
      vecs[6]  = mk(1, 32'h200, 0,            4'h0, 0, 0,            0, 0,            1, 32'h200, 0,            4'h0, 3'd0);
      vecs[7]  = mk(1, 32'h200, 0,            4'h0, 1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1, 32'h200, 0,            4'h0, 3'd0);
      vecs[8]  = mk(0, 0,       0,            4'h0, 0, 32'hCAFEF00D, 0, 0,            0, 0,      0,            4'h0, 3'd0);
      vecs[9]  = mk(0, 0,       0,            4'h0, 1, 32'hCAFEF00D, 0, 0,            0, 0,      0,            4'h0, 3'd0);
      vecs[10] = mk(0, 0,       0,            4'h0, 1, 32'hCAFEF00D, 0, 0,            0, 0,      0,            4'h0, 3'd0);

      // reset state, checked before any clock edge
      #1 rst = 1'b0;
      #2;
      chk("rst_mem_valid", 32'(mem_valid), 32'd0);
      chk("rst_level", 32'(wbuf_level), 32'd0);
      chk("rst_up_ready", 32'(up_ready), 32'd0);
      chk("rst_up_rdata", up_rdata, 32'd0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;

      // per-cycle table: single write, pass-through read, stray mem_ready
      for (int i = 0; i < 11; i++) begin
         up_valid = vecs[i].v; up_addr = vecs[i].a; up_wdata = vecs[i].d; up_wstrb = vecs[i].s;
         mem_ready = vecs[i].mr; mem_rdata = vecs[i].mrd;
         @(negedge clk);
         chk($sformatf("v%0d_up_ready", i), 32'(up_ready), 32'(vecs[i].e_rdy));
         chk($sformatf("v%0d_up_rdata", i), up_rdata, vecs[i].e_rdata);
         chk($sformatf("v%0d_mem_valid", i), 32'(mem_valid), 32'(vecs[i].e_mv));
         chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_maddr);
         chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].e_mwdata);
         chk($sformatf("v%0d_mem_wstrb", i), 32'(mem_wstrb), 32'(vecs[i].e_mstrb));
         chk($sformatf("v%0d_level", i), 32'(wbuf_level), 32'(vecs[i].e_lvl));
         @(posedge clk); #1;
      end
      up_valid = 1'b0; up_addr = '0; up_wdata = '0; up_wstrb = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      exp_q.push_back({32'h100, 32'hDEADBEEF, 4'hF});
      exp_q.push_back({32'h200, 32'h0, 4'h0});
      cmp_q("tbl");

      // full FIFO: fifth write held until a slot frees, acked one edge after the pop
      for (int i = 0; i < 4; i++) begin
         wr(32'(i * 4), 32'h1000_0000 | 32'(i), 4'hF, lat);
         chk("full_lat", 32'(lat), 32'd1);
      end
      chk("full_level", 32'(wbuf_level), 32'd4);
      up_valid = 1'b1; up_addr = 32'h10; up_wdata = 32'h1000_0004; up_wstrb = 4'hF;
      repeat (3) begin
         @(posedge clk); #1;
         chk("full_hold", 32'(up_ready), 32'd0);
      end
      chk("full_hold_level", 32'(wbuf_level), 32'd4);
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      chk("full_pop_noack", 32'(up_ready), 32'd0);
      chk("full_pop_level", 32'(wbuf_level), 32'd3);
      @(posedge clk); #1;
      chk("full_ack", 32'(up_ready), 32'd1);
      chk("full_ack_level", 32'(wbuf_level), 32'd4);
      up_valid = 1'b0; up_wstrb = '0;
      exp_q.push_back({32'h10, 32'h1000_0004, 4'hF});
      @(posedge clk); #1;
      drain("full_drain");
      cmp_q("full");

      // read behind two buffered writes; rdata only in the completion cycle
      wr(32'h300, 32'h33, 4'hF, lat);
      wr(32'h304, 32'h44, 4'h3, lat);
      up_valid = 1'b1; up_addr = 32'h200; up_wdata = '0; up_wstrb = 4'h0;
      mem_rdata = 32'h12345678;
      got = 1'b0;
      for (int k = 0; k < 30; k++) begin
         mem_ready = (k % 2 == 1);
         @(negedge clk);
         if (up_ready) begin
            chk("rd_rdata", up_rdata, 32'h12345678);
            chk("rd_addr", mem_addr, 32'h200);
            chk("rd_wstrb", 32'(mem_wstrb), 32'd0);
            chk("rd_level", 32'(wbuf_level), 32'd0);
            got = 1'b1;
         end else begin
            chk("rd_rdata_zero", up_rdata, 32'd0);
         end
         @(posedge clk); #1;
         if (got) break;
      end
      up_valid = 1'b0; up_addr = '0; mem_ready = 1'b0;
      if (!got) timeout("rd_complete");
      @(negedge clk);
      chk("rd_after_zero", up_rdata, 32'd0);
      exp_q.push_back({32'h200, 32'h0, 4'h0});
      cmp_q("rd");

      // wrap-around with memory always ready
      max_level = 0;
      mem_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wr(32'h400 + 32'(i * 4), 32'h0101_0101 * 32'(i + 1), (i % 2 == 0) ? 4'hF : 4'h5, lat);
         chk("wrap_lat", 32'(lat), 32'd1);
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      chk("wrap_level", 32'(wbuf_level), 32'd0);
      chk("wrap_max_level", 32'(max_level), 32'd1);
      cmp_q("wrap");

      // push and pop on the same edge
      wr(32'h500, 32'h55, 4'hF, lat);
      wr(32'h504, 32'h66, 4'hF, lat);
      chk("col_pre_level", 32'(wbuf_level), 32'd2);
      up_valid = 1'b1; up_addr = 32'h508; up_wdata = 32'h77; up_wstrb = 4'hC;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0; up_valid = 1'b0; up_wstrb = '0;
      chk("col_level", 32'(wbuf_level), 32'd2);
      chk("col_ack", 32'(up_ready), 32'd1);
      chk("col_head", mem_addr, 32'h504);
      exp_q.push_back({32'h508, 32'h77, 4'hC});
      @(posedge clk); #1;
      drain("col_drain");
      cmp_q("col");

      // asynchronous reset with three writes pending
      wr(32'h600, 32'h1, 4'hF, lat);
      wr(32'h604, 32'h2, 4'hF, lat);
      wr(32'h608, 32'h3, 4'hF, lat);
      chk("arst_pre_level", 32'(wbuf_level), 32'd3);
      chk("arst_pre_valid", 32'(mem_valid), 32'd1);
      @(negedge clk); #2;
      rst = 1'b0;
      #1;
      chk("arst_mem_valid", 32'(mem_valid), 32'd0);
      chk("arst_level", 32'(wbuf_level), 32'd0);
      chk("arst_up_ready", 32'(up_ready), 32'd0);
      exp_q.delete();
      @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      wr(32'h700, 32'hA5A5_0707, 4'hF, lat);
      chk("arst_new_lat", 32'(lat), 32'd1);
      drain("arst_drain");
      cmp_q("arst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_wbuf.md
# mem_wbuf

Posted-write buffer between the two-master memory arbiter's master port and the memory/peripheral bus. Writes are acknowledged as soon as they enter a DEPTH-entry FIFO and are drained to memory in order. Reads pass through only after the FIFO has fully drained, which preserves program order and rules out read-after-write hazards without address comparison. Both sides use the valid/ready memory handshake already used on the bus.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, ≥ 2
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- up_valid  in  1  request from arbiter; held until up_ready
- up_ready  out  1  one-cycle completion pulse to arbiter
- up_addr  in  32  request address
- up_rdata  out  32  read data; valid only with read completion, else 0
- up_wdata  in  32  write data
- up_wstrb  in  4  byte strobes; 0 means read, nonzero means write
- mem_valid  out  1  request to memory
- mem_ready  in  1  memory completion pulse
- mem_addr  out  32  memory address
- mem_rdata  in  32  memory read data
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte strobes
- wbuf_level  out  clog2(DEPTH)+1  current FIFO occupancy

## Operation
- FIFO entry is {addr, wdata, wstrb}. Write and read pointers are clog2(DEPTH) bits and wrap modulo DEPTH. wbuf_level ranges 0..DEPTH.
- States: IDLE, READ.
- Push: at an edge where up_valid=1, up_wstrb≠0, wbuf_level<DEPTH, state=IDLE, and the registered up_ready=0 (no double-push during the ack cycle).
  - The entry is written at the write pointer.
  - up_ready is registered to 1 for exactly the next cycle.
  - up_rdata=0 on a write ack.
- Full: while wbuf_level=DEPTH, the write is held and up_ready stays 0. A push is never taken in the same edge as the pop that frees a slot; it is taken on the following edge.
- Drain:
  - mem_valid = (wbuf_level≠0) or (state=READ).
  - When wbuf_level≠0, mem_addr/mem_wdata/mem_wstrb show the FIFO head.
  - A pop occurs on any edge with wbuf_level≠0 and mem_ready=1.
- Simultaneous push and pop: level unchanged; both pointers advance.
- Read entry: in IDLE, with up_valid=1, up_wstrb=0, and wbuf_level=0, go to READ.
- READ state:
  - mem_addr=up_addr, mem_wdata=up_wdata, mem_wstrb=0.
  - up_ready=mem_ready (combinational); up_rdata=mem_ready ? mem_rdata : 0.
  - On mem_ready, return to IDLE. No pushes are taken in READ.
- mem_ready while mem_valid=0 is ignored.

## Timing
- Reset (rst=0, asynchronous, no clock needed):
  - state=IDLE; pointers=0; wbuf_level=0; up_ready=0.
  - Therefore mem_valid=0, mem_wstrb=0, up_rdata=0.
  - FIFO contents are discarded; entry RAM need not reset.
- Reset mid-operation: pending writes are lost and mem_valid drops in the same cycle rst falls.
- Write ack latency: request at cycle N → up_ready=1 at cycle N+1 when not full. Pushed data appears on mem_* at cycle N+1 if the FIFO was empty.
- Sustained write rate: one write per 2 cycles (request, ack).
- Read latency: reads wait until wbuf_level=0. The state becomes READ one edge after that condition is seen; mem_valid rises that cycle. up_ready coincides with mem_ready.
- Drain order equals push order. Reads never overtake buffered writes.

## Test plan
- Single write: after reset, write addr=0x100, wdata=0xDEADBEEF, wstrb=0xF at cycle 0 → up_ready=1 at cycle 1 only. mem_valid=1 with the same fields from cycle 1. mem_ready at cycle 3 → wbuf_level 1→0, mem_valid=0 at cycle 4.
- Full FIFO (DEPTH=4), mem_ready held 0, five writes 0x0..0x10:
  - First four acked; wbuf_level=4; fifth held with up_ready=0.
  - One mem_ready pulse → fifth acked on the second edge after it.
  - Memory sees 0x0,0x4,0x8,0xC,0x10 in order.
- Read behind writes: two writes queued, then read addr=0x200:
  - mem sees both writes, then a read with wstrb=0.
  - mem_ready with mem_rdata=0x12345678 → up_ready=1, up_rdata=0x12345678 in the same cycle; up_rdata=0 in all other cycles.
- Wrap-around: 10 writes with mem_ready=1 whenever mem_valid=1 → all drained in order, pointers wrap past 3→0, wbuf_level never exceeds 1.
- Push/pop collision: wbuf_level=2, new write pushed on the same edge as a pop → wbuf_level stays 2, head advances, new entry at the tail.
- Async reset mid-drain: wbuf_level=3, mem_valid=1, drive rst=0 between edges → mem_valid=0 and wbuf_level=0 immediately. After rst=1, a new write is acked in 1 cycle and drained correctly.
